// File: rtl/tx_axis_arbiter.sv
// Frame-granular round-robin arbiter sharing the TX MAC AXI-Stream input among NUM_PORTS sources.
// Grant is held from arbitration until tlast is accepted; data path is a zero-latency mux.
module tx_axis_arbiter #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                             i_clk,
  input  logic                             i_reset_n,
  input  logic [NUM_PORTS-1:0]             i_port_enable,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]             s_axis_tlast,
  output logic [NUM_PORTS-1:0]             s_axis_trdy,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
  output logic                             m_axis_tvalid,
  output logic                             m_axis_tlast,
  input  logic                             m_axis_trdy,
  output logic [NUM_PORTS-1:0]             o_grant,
  output logic                             o_busy,
  output logic                             o_frame_done,
  output logic                             o_underrun
);

  localparam int unsigned IDX_W  = $clog2(NUM_PORTS);
  localparam int unsigned DSEL_W = $clog2(NUM_PORTS * DATA_WIDTH);
  localparam int unsigned KSEL_W = $clog2(NUM_PORTS * KEEP_WIDTH);

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_PASS = 1'b1
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_grant;
  logic [IDX_W-1:0]   r_last_grant;
  logic               r_beat_seen;

  logic [NUM_PORTS-1:0] w_elig;
  logic [IDX_W-1:0]     w_idx;
  logic [IDX_W-1:0]     w_sel;
  logic                 w_sel_valid;
  logic                 w_pass;
  logic                 w_accept;
  logic [DSEL_W-1:0]    w_doff;
  logic [KSEL_W-1:0]    w_koff;

  assign w_elig   = s_axis_tvalid & i_port_enable;
  assign w_pass   = (r_state == ST_PASS);
  assign w_accept = m_axis_tvalid & m_axis_trdy;
  assign w_doff   = DSEL_W'(int'(r_grant) * int'(DATA_WIDTH));
  assign w_koff   = KSEL_W'(int'(r_grant) * int'(KEEP_WIDTH));

  // Rotating priority search starting just above the previous winner
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel       = '0;
    w_idx       = '0;
    for (int k = 1; k <= int'(NUM_PORTS); k++) begin
      w_idx = IDX_W'((int'(r_last_grant) + k) % int'(NUM_PORTS));
      if (!w_sel_valid && w_elig[w_idx]) begin
        w_sel_valid = 1'b1;
        w_sel       = w_idx;
      end
    end
  end

  // Zero-latency pass-through of the granted source; quiet while arbitrating
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_trdy   = '0;
    if (w_pass) begin
      m_axis_tdata         = s_axis_tdata[w_doff +: DATA_WIDTH];
      m_axis_tkeep         = s_axis_tkeep[w_koff +: KEEP_WIDTH];
      m_axis_tvalid        = s_axis_tvalid[r_grant];
      m_axis_tlast         = s_axis_tlast[r_grant];
      s_axis_trdy[r_grant] = m_axis_trdy;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state      <= ST_ARB;
      r_grant      <= '0;
      r_last_grant <= IDX_W'(NUM_PORTS - 1);
      r_beat_seen  <= 1'b0;
      o_grant      <= '0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_underrun   <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      o_underrun   <= 1'b0;
      if (r_state == ST_ARB) begin
        if (w_sel_valid) begin
          r_grant     <= w_sel;
          o_grant     <= NUM_PORTS'(1) << w_sel;
          o_busy      <= 1'b1;
          r_beat_seen <= 1'b0;
          r_state     <= ST_PASS;
        end
      end else begin
        if (w_accept) begin
          r_beat_seen <= 1'b1;
          if (m_axis_tlast) begin
            o_frame_done <= 1'b1;
            r_last_grant <= r_grant;
            o_grant      <= '0;
            o_busy       <= 1'b0;
            r_state      <= ST_ARB;
          end
        end
        // A gap after the first beat is a source underrun; the grant is kept
        if (m_axis_trdy && !m_axis_tvalid && r_beat_seen) begin
          o_underrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tx_axis_arbiter.sv
// Bench for tx_axis_arbiter: directed vector table, reset-mid-frame sequence and
// randomized frame traffic against a frame-level scoreboard with rotation predictor.
module tb_tx_axis_arbiter;

  localparam int unsigned NP = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned KW = 4;
  localparam int          FRAMES_PER_PORT = 5;
  localparam int          MAX_CYC = 5000;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NP-1:0]     en;
  logic [NP*DW-1:0]  s_tdata;
  logic [NP*KW-1:0]  s_tkeep;
  logic [NP-1:0]     s_tvalid;
  logic [NP-1:0]     s_tlast;
  logic [NP-1:0]     s_trdy;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_trdy;
  logic [NP-1:0]     grant;
  logic              busy;
  logic              fd;
  logic              ur;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tx_axis_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_port_enable (en),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_trdy   (s_trdy),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_trdy   (m_trdy),
    .o_grant       (grant),
    .o_busy        (busy),
    .o_frame_done  (fd),
    .o_underrun    (ur)
  );

  typedef struct {
    logic [3:0] en;
    logic [3:0] valid;
    logic [3:0] last;
    logic       mrdy;
    logic [3:0] grant;
    logic       mvalid;
    logic       mlast;
    logic [3:0] srdy;
    logic       fd;
    logic       ur;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  vec_t  tbl[16];
  beat_t mem[NP][64];
  int    wr[NP];
  int    rd[NP];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] tbl_data(input int p);
    return 32'hD0D0_0000 | DW'(p);
  endfunction

  function automatic logic [KW-1:0] tbl_keep(input int p);
    logic [KW-1:0] full;
    full = 4'hF;
    return full >> p;
  endfunction

  function automatic int oh_idx(input logic [NP-1:0] v);
    for (int i = 0; i < int'(NP); i++) if (v[i]) return i;
    return 0;
  endfunction

  // Winner = first requesting port after the previous winner, wrapping around
  function automatic logic [NP-1:0] rr_pick(input logic [NP-1:0] elig, input int last);
    for (int k = 1; k <= int'(NP); k++) begin
      int idx;
      idx = (last + k) % int'(NP);
      if (elig[idx]) return NP'(1) << idx;
    end
    return '0;
  endfunction

  task automatic set_static(input logic [3:0] e, input logic [3:0] v, input logic [3:0] l,
                            input logic r);
    en       = e;
    s_tvalid = v;
    s_tlast  = l;
    m_trdy   = r;
    for (int p = 0; p < int'(NP); p++) begin
      s_tdata[p*DW +: DW] = tbl_data(p);
      s_tkeep[p*KW +: KW] = tbl_keep(p);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_static(4'hF, 4'h0, 4'h0, 1'b1);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int exp_last, cur, beats, frames_done, cyc, total_frames;
    logic [NP-1:0] exp_grant, nxt_grant;
    logic exp_ur, exp_fd, nxt_ur, nxt_fd, drained;

    //          en     valid  last   mrdy  grant  mvld  mlast srdy   fd    ur
    tbl[0]  = '{4'hF, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[1]  = '{4'hF, 4'h6, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[2]  = '{4'hF, 4'h6, 4'h0, 1'b0, 4'h2, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[3]  = '{4'hF, 4'h6, 4'h0, 1'b1, 4'h2, 1'b1, 1'b0, 4'h2, 1'b0, 1'b0};
    tbl[4]  = '{4'hF, 4'h4, 4'h0, 1'b1, 4'h2, 1'b0, 1'b0, 4'h2, 1'b0, 1'b0};
    tbl[5]  = '{4'hF, 4'h6, 4'h2, 1'b1, 4'h2, 1'b1, 1'b1, 4'h2, 1'b0, 1'b1};
    tbl[6]  = '{4'hF, 4'h6, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0};
    tbl[7]  = '{4'hF, 4'h6, 4'h4, 1'b1, 4'h4, 1'b1, 1'b1, 4'h4, 1'b0, 1'b0};
    tbl[8]  = '{4'hD, 4'h6, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0};
    tbl[9]  = '{4'h0, 4'h6, 4'h4, 1'b1, 4'h4, 1'b1, 1'b1, 4'h4, 1'b0, 1'b0};
    tbl[10] = '{4'h0, 4'hF, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0};
    tbl[11] = '{4'hF, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0};
    tbl[12] = '{4'hF, 4'hF, 4'hF, 1'b1, 4'h8, 1'b1, 1'b1, 4'h8, 1'b0, 1'b0};
    tbl[13] = '{4'hF, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0};
    tbl[14] = '{4'hF, 4'hF, 4'hF, 1'b1, 4'h1, 1'b1, 1'b1, 4'h1, 1'b0, 1'b0};
    tbl[15] = '{4'hF, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0};

    do_reset();
    @(negedge clk);
    chk("reset_grant", grant, 0);
    chk("reset_busy", busy, 0);
    chk("reset_fd", fd, 0);
    chk("reset_ur", ur, 0);
    chk("reset_mvalid", m_tvalid, 0);
    chk("reset_srdy", s_trdy, 0);

    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1 set_static(tbl[i].en, tbl[i].valid, tbl[i].last, tbl[i].mrdy);
      @(negedge clk);
      chk($sformatf("vec%0d_grant", i), grant, tbl[i].grant);
      chk($sformatf("vec%0d_busy", i), busy, |tbl[i].grant);
      chk($sformatf("vec%0d_mvalid", i), m_tvalid, tbl[i].mvalid);
      chk($sformatf("vec%0d_srdy", i), s_trdy, tbl[i].srdy);
      chk($sformatf("vec%0d_fd", i), fd, tbl[i].fd);
      chk($sformatf("vec%0d_ur", i), ur, tbl[i].ur);
      if (tbl[i].grant != 0) begin
        chk($sformatf("vec%0d_mlast", i), m_tlast, tbl[i].mlast);
        chk($sformatf("vec%0d_tdata", i), m_tdata, tbl_data(oh_idx(tbl[i].grant)));
        chk($sformatf("vec%0d_tkeep", i), m_tkeep, tbl_keep(oh_idx(tbl[i].grant)));
      end
    end

    // Reset lands on word 5 of a port-1 frame
    do_reset();
    @(posedge clk);
    #1 set_static(4'hF, 4'h2, 4'h0, 1'b1);
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rst_word%0d_grant", i), grant, 4'h2);
    end
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_grant", grant, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_mvalid", m_tvalid, 0);
    chk("rst_mid_srdy", s_trdy, 0);
    chk("rst_mid_fd", fd, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_arb_grant", grant, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_regrant", grant, 4'h2);
    chk("rst_regrant_mvalid", m_tvalid, 1);

    // Port 0 wins first out of reset when it competes
    do_reset();
    @(posedge clk);
    #1 set_static(4'hF, 4'h3, 4'h0, 1'b0);
    @(negedge clk);
    chk("first_arb_idle", grant, 0);
    @(posedge clk);
    @(negedge clk);
    chk("first_grant_p0", grant, 4'h1);

    // Randomized frames with random gaps, backpressure and enable noise
    total_frames = 0;
    for (int p = 0; p < int'(NP); p++) begin
      wr[p] = 0;
      rd[p] = 0;
      for (int f = 0; f < FRAMES_PER_PORT; f++) begin
        int len;
        len = int'($urandom_range(1, 6));
        for (int b = 0; b < len; b++) begin
          mem[p][wr[p]].d = $urandom;
          mem[p][wr[p]].k = KW'($urandom_range(1, 15));
          mem[p][wr[p]].l = (b == len - 1);
          wr[p]++;
        end
        total_frames++;
      end
    end

    do_reset();
    exp_last = int'(NP) - 1;
    exp_grant = '0;
    exp_ur = 1'b0;
    exp_fd = 1'b0;
    cur = 0;
    beats = 0;
    frames_done = 0;
    cyc = 0;
    while (cyc < MAX_CYC) begin
      drained = 1'b1;
      for (int p = 0; p < int'(NP); p++) if (rd[p] < wr[p]) drained = 1'b0;
      if (drained && exp_grant == 0 && !exp_fd && !exp_ur) break;

      @(posedge clk);
      #1;
      m_trdy = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < int'(NP); p++) begin
        en[p] = ($urandom_range(0, 3) != 0);
        if (rd[p] < wr[p] && $urandom_range(0, 3) != 0) begin
          s_tvalid[p] = 1'b1;
          s_tdata[p*DW +: DW] = mem[p][rd[p]].d;
          s_tkeep[p*KW +: KW] = mem[p][rd[p]].k;
          s_tlast[p] = mem[p][rd[p]].l;
        end else begin
          s_tvalid[p] = 1'b0;
          s_tdata[p*DW +: DW] = $urandom;
          s_tkeep[p*KW +: KW] = KW'($urandom);
          s_tlast[p] = 1'($urandom_range(0, 1));
        end
      end
      @(negedge clk);

      chk("rnd_grant", grant, exp_grant);
      chk("rnd_busy", busy, |exp_grant);
      chk("rnd_fd", fd, exp_fd);
      chk("rnd_ur", ur, exp_ur);
      nxt_ur = 1'b0;
      nxt_fd = 1'b0;
      nxt_grant = exp_grant;
      if (exp_grant == 0) begin
        chk("rnd_idle_mvalid", m_tvalid, 0);
        chk("rnd_idle_srdy", s_trdy, 0);
        nxt_grant = rr_pick(s_tvalid & en, exp_last);
        if (nxt_grant != 0) begin
          cur = oh_idx(nxt_grant);
          beats = 0;
        end
      end else begin
        chk("rnd_mvalid", m_tvalid, s_tvalid[cur]);
        chk("rnd_srdy", s_trdy, m_trdy ? exp_grant : '0);
        if (s_tvalid[cur] && m_trdy) begin
          chk("rnd_tdata", m_tdata, mem[cur][rd[cur]].d);
          chk("rnd_tkeep", m_tkeep, mem[cur][rd[cur]].k);
          chk("rnd_tlast", m_tlast, mem[cur][rd[cur]].l);
          beats++;
          if (mem[cur][rd[cur]].l) begin
            nxt_fd = 1'b1;
            nxt_grant = '0;
            exp_last = cur;
            frames_done++;
          end
          rd[cur]++;
        end else if (m_trdy && beats > 0) begin
          nxt_ur = 1'b1;
        end
      end
      exp_grant = nxt_grant;
      exp_ur = nxt_ur;
      exp_fd = nxt_fd;
      cyc++;
    end
    chk("rnd_no_timeout", cyc < MAX_CYC, 1);
    chk("rnd_frames", frames_done, total_frames);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
